// File: rtl/mem_access_pkg.sv
// Shared encodings and lane helpers for the load/store stage.
// MEM_MISALIGN_TRAP_EN enables misaligned-access trapping in mem_access_unit.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic [3:0] lane_strobe(
    input logic [1:0] size,
    input logic [1:0] a
  );
    logic [3:0] s;
    s = 4'b0000;
    unique case (1'b1)
      size == SZ_BYTE: s = 4'b0001 << a;
      size == SZ_HALF: s = a[1] ? 4'b1100 : 4'b0011;
      size == SZ_WORD: s = 4'b1111;
      default:         s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] lane_extract(
    input logic [31:0] rdata,
    input logic [1:0]  size,
    input logic [1:0]  a,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{a, 3'b000} +: 8];
    h = a[1] ? rdata[31:16] : rdata[15:0];
    r = 32'h0;
    unique case (1'b1)
      size == SZ_BYTE: r = {{24{b[7] & ~uns}}, b};
      size == SZ_HALF: r = {{16{h[15] & ~uns}}, h};
      size == SZ_WORD: r = rdata;
      default:         r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    return ((size == SZ_HALF) && a[0]) ||
           ((size == SZ_WORD) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane placement for stores and extraction/extension for loads.
// Purely combinational.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        uns,
  input  logic [31:0] wsrc,
  input  logic [31:0] rdata,
  output logic [3:0]  strobe,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  always_comb begin
    strobe = lane_strobe(size, addr_lo);
    ldata  = lane_extract(rdata, size, addr_lo, uns);
    wdata  = 32'h0;
    unique case (1'b1)
      size == SZ_BYTE: wdata = {4{wsrc[7:0]}};
      size == SZ_HALF: wdata = {2{wsrc[15:0]}};
      size == SZ_WORD: wdata = wsrc;
      default:         wdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: byte strobes, lane placement, slow-region wait states.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 30,
  parameter int WAIT_CYCLES = 1,
  parameter int SLOW_BIT    = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] din,
  input  logic [15:0]       imme,
  input  logic              mem_to_reg,
  input  logic              lui_sig,
  output logic              stall,
  output logic [DATA_W-1:0] dout,
  output logic              misalign,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce,
  output logic [3:0]        ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
  localparam bit HAS_WAIT = (WAIT_CYCLES != 0);

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] h_addr;
  logic [1:0]        h_lo;
  logic [1:0]        h_size;
  logic              h_uns;
  logic              h_rd;
  logic [3:0]        h_we;
  logic [31:0]       h_wdata;
  logic [31:0]       rhold;

  logic [1:0] a;
  logic       req, mis_c, mis_i, go, slow_c, accept_slow, in_done;
  logic [1:0]  al_size, al_lo;
  logic        al_uns;
  logic [31:0] al_rdata, lane_wdata, lane_ldata, ldata;
  logic [3:0]  lane_we;

  assign a   = alu_result[1:0];
  assign req = (mem_read | mem_write) & (mem_size != SZ_NONE);

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_c = req & misaligned(mem_size, a);
`else
  assign mis_c = 1'b0;
`endif

  assign mis_i       = (state == ST_IDLE) & mis_c;
  assign go          = req & ~mis_c;
  assign slow_c      = HAS_WAIT && !alu_result[SLOW_BIT+2];
  assign accept_slow = (state == ST_IDLE) & go & slow_c;
  assign in_done     = (state == ST_DONE);

  // DONE replays the captured access against the held read data
  assign al_size  = in_done ? h_size : mem_size;
  assign al_lo    = in_done ? h_lo   : a;
  assign al_uns   = in_done ? h_uns  : mem_unsigned;
  assign al_rdata = in_done ? rhold  : ram_rdata;

  mem_lane_align u_align (
    .size    (al_size),
    .addr_lo (al_lo),
    .uns     (al_uns),
    .wsrc    (din),
    .rdata   (al_rdata),
    .strobe  (lane_we),
    .wdata   (lane_wdata),
    .ldata   (lane_ldata)
  );

  always_comb begin
    ram_addr  = '0;
    ram_ce    = 1'b0;
    ram_we    = 4'b0000;
    ram_wdata = '0;
    stall     = 1'b0;
    misalign  = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          ram_addr  = alu_result[ADDR_W+1:2];
          ram_ce    = go;
          ram_we    = (go & mem_write) ? lane_we : 4'b0000;
          ram_wdata = (go & mem_write) ? lane_wdata : '0;
          stall     = accept_slow;
          misalign  = mis_i;
        end
        ST_WAIT: begin
          ram_addr  = h_addr;
          ram_ce    = 1'b1;
          ram_we    = h_we;
          ram_wdata = h_wdata;
          stall     = 1'b1;
        end
        default: ram_addr = h_addr;
      endcase
    end
  end

  always_comb begin
    ldata = lane_ldata;
    if (in_done && !h_rd) ldata = '0;
    if (mis_i)            ldata = '0;
    dout = alu_result;
    if (rst)             dout = '0;
    else if (lui_sig)    dout = {imme, 16'h0};
    else if (mem_to_reg) dout = ldata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      h_addr  <= '0;
      h_lo    <= 2'b00;
      h_size  <= 2'b00;
      h_uns   <= 1'b0;
      h_rd    <= 1'b0;
      h_we    <= 4'b0000;
      h_wdata <= '0;
      rhold   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept_slow) begin
          state   <= ST_WAIT;
          cnt     <= CNT_INIT;
          h_addr  <= alu_result[ADDR_W+1:2];
          h_lo    <= a;
          h_size  <= mem_size;
          h_uns   <= mem_unsigned;
          h_rd    <= mem_read & ~mem_write;
          h_we    <= mem_write ? lane_we : 4'b0000;
          h_wdata <= lane_wdata;
        end
        ST_WAIT: if (cnt == 4'd0) begin
          rhold <= ram_rdata;
          state <= ST_DONE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
